// File: rtl/music_pkg.sv
// Shared definitions for the note playback path: note RAM geometry, player
// states and the note-code to tone half-period lookup (50 MHz clock).
package music_pkg;

  localparam int NOTE_W    = 6;
  localparam int DEPTH     = 40;
  localparam int NUM_NOTES = 38;  // codes 1..37 = C4..C7 chromatic
  localparam int HP_W      = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_SOUND,
    ST_GAP
  } player_state_e;

  // Zero marks a silent code (rest or out of range). The sim table keeps
  // tones short enough to observe several toggles inside a tiny beat.
  function automatic logic [HP_W-1:0] half_period(input logic [NOTE_W-1:0] note,
                                                  input logic              sim);
    logic [HP_W-1:0] hp;
    hp = '0;
    if (note != '0 && note < NOTE_W'(NUM_NOTES)) begin
      if (sim) begin
        hp = HP_W'(note % 6'd3) + HP_W'(1);
      end else begin
        case (note)
          6'd1:  hp = 17'd95556;
          6'd2:  hp = 17'd90193;
          6'd3:  hp = 17'd85131;
          6'd4:  hp = 17'd80353;
          6'd5:  hp = 17'd75843;
          6'd6:  hp = 17'd71586;
          6'd7:  hp = 17'd67568;
          6'd8:  hp = 17'd63776;
          6'd9:  hp = 17'd60197;
          6'd10: hp = 17'd56818;
          6'd11: hp = 17'd53629;
          6'd12: hp = 17'd50619;
          6'd13: hp = 17'd47778;
          6'd14: hp = 17'd45097;
          6'd15: hp = 17'd42566;
          6'd16: hp = 17'd40177;
          6'd17: hp = 17'd37922;
          6'd18: hp = 17'd35793;
          6'd19: hp = 17'd33784;
          6'd20: hp = 17'd31888;
          6'd21: hp = 17'd30099;
          6'd22: hp = 17'd28409;
          6'd23: hp = 17'd26815;
          6'd24: hp = 17'd25310;
          6'd25: hp = 17'd23889;
          6'd26: hp = 17'd22548;
          6'd27: hp = 17'd21283;
          6'd28: hp = 17'd20088;
          6'd29: hp = 17'd18961;
          6'd30: hp = 17'd17897;
          6'd31: hp = 17'd16892;
          6'd32: hp = 17'd15944;
          6'd33: hp = 17'd15049;
          6'd34: hp = 17'd14205;
          6'd35: hp = 17'd13407;
          6'd36: hp = 17'd12655;
          6'd37: hp = 17'd11945;
          default: hp = '0;
        endcase
      end
    end
    return hp;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Reloadable square-wave divider. Dropping en restarts the phase, so every
// note that enters SOUND begins from a fresh low half-cycle.
module tone_gen (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [music_pkg::HP_W-1:0] half_period,
  output logic                        spk
);

  logic [music_pkg::HP_W-1:0] cnt_q, cnt_d;
  logic                       spk_q, spk_d;

  always_comb begin
    cnt_d = '0;
    spk_d = 1'b0;
    if (en) begin
      if (cnt_q + music_pkg::HP_W'(1) >= half_period) begin
        cnt_d = '0;
        spk_d = ~spk_q;
      end else begin
        cnt_d = cnt_q + music_pkg::HP_W'(1);
        spk_d = spk_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  // Gate combinationally so the gap and stop silence the output at once.
  assign spk = spk_q & en;

endmodule

// File: rtl/note_player.sv
// Read side of the composition RAM: walks indices 0..i_note-1, holding each
// note for one beat (sound then articulation gap) and driving the speaker.
module note_player #(
  parameter int DEPTH       = 40,
  parameter int NOTE_W      = 6,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 625_000,
  parameter bit SIM_LUT     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [5:0]        i_note,
  input  logic [NOTE_W-1:0] rd_data,
  output logic [5:0]        rd_addr,
  output logic [NOTE_W-1:0] note_out,
  output logic [5:0]        pos_play,
  output logic              playing,
  output logic              done,
  output logic              spk
);
  import music_pkg::*;

  localparam int            BW         = $clog2(BEAT_CYCLES);
  localparam logic [BW-1:0] SOUND_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEAT_CYCLES - 1);
  localparam logic [6:0]    DEPTH_LIM  = 7'(DEPTH);

  player_state_e     state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [5:0]        addr_q, addr_d;
  logic [5:0]        pos_q, pos_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;
  logic [6:0]        limit, next_pos;
  logic              more, beat_end, abort;
  logic              tone_en;
  logic [HP_W-1:0]   hp;

  // i_note is sampled live; clamp so addressing never leaves the RAM.
  assign limit    = ({1'b0, i_note} > DEPTH_LIM) ? DEPTH_LIM : {1'b0, i_note};
  assign next_pos = {1'b0, pos_q} + 7'd1;
  assign more     = next_pos < limit;
  assign beat_end = beat_q == BEAT_LAST;
  assign abort    = stop && state_q != ST_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (play && i_note != '0) state_d = ST_FETCH;
        ST_FETCH:   state_d = ST_WAIT_RD;
        ST_WAIT_RD: state_d = ST_SOUND;
        ST_SOUND:   if (beat_q == SOUND_LAST) state_d = ST_GAP;
        ST_GAP:     if (beat_end) state_d = (more || loop_en) ? ST_FETCH : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d    = addr_q;
    pos_d     = pos_q;
    note_d    = note_q;
    playing_d = playing_q;
    done_d    = 1'b0;
    beat_d    = beat_q;
    if (abort) begin
      note_d    = '0;
      playing_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            if (i_note == '0) begin
              done_d = 1'b1;
            end else begin
              addr_d    = '0;
              pos_d     = '0;
              playing_d = 1'b1;
            end
          end
        end
        ST_WAIT_RD: begin
          note_d = rd_data;
          beat_d = '0;
        end
        ST_SOUND: beat_d = beat_q + BW'(1);
        ST_GAP: begin
          beat_d = beat_q + BW'(1);
          if (beat_end) begin
            if (more) begin
              pos_d  = next_pos[5:0];
              addr_d = next_pos[5:0];
            end else if (loop_en) begin
              pos_d  = '0;
              addr_d = '0;
            end else begin
              done_d    = 1'b1;
              note_d    = '0;
              playing_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q    <= '0;
      addr_q    <= '0;
      pos_q     <= '0;
      note_q    <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      pos_q     <= pos_d;
      note_q    <= note_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign hp      = half_period(note_q, SIM_LUT);
  assign tone_en = (state_q == ST_SOUND) && (hp != '0);

  tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .en          (tone_en),
    .half_period (hp),
    .spk         (spk)
  );

  assign rd_addr  = addr_q;
  assign pos_play = pos_q;
  assign note_out = note_q;
  assign playing  = playing_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player with a tiny beat (8 clocks, 2 gap) and the sim tone
// table; a beat-phase reference model predicts every output each cycle.
module tb_note_player;

  localparam int BEAT  = 8;
  localparam int GAP   = 2;
  localparam int DEPTH = 40;
  localparam int NN    = 38;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [5:0] i_note = '0;
  logic [5:0] rd_data;
  logic [5:0] rd_addr, note_out, pos_play;
  logic       playing, done, spk;

  logic [5:0] ram [0:63];
  int checks = 0;
  int failures = 0;
  int dn_cnt = 0;

  // Model: m_ph is the clock position inside the current beat
  // (0 fetch, 1 read, 2.. sound, then gap, last = BEAT+1).
  bit m_act, m_done;
  int m_idx, m_ph, m_note;

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= ram[rd_addr];

  note_player #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .SIM_LUT     (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .stop     (stop),
    .loop_en  (loop_en),
    .i_note   (i_note),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .note_out (note_out),
    .pos_play (pos_play),
    .playing  (playing),
    .done     (done),
    .spk      (spk)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int hp(input int code);
    if (code == 0 || code >= NN) return 0;
    return code % 3 + 1;
  endfunction

  function automatic int m_spk();
    int k, h;
    if (!m_act) return 0;
    k = m_ph - 2;
    h = hp(m_note);
    if (k < 0 || k >= BEAT - GAP || h == 0) return 0;
    return (k / h) % 2;
  endfunction

  task automatic m_reset();
    m_act = 0; m_done = 0; m_idx = 0; m_ph = 0; m_note = 0;
  endtask

  task automatic m_step(input bit p, input bit s, input bit lp, input int n);
    int lim;
    m_done = 0;
    lim = (n > DEPTH) ? DEPTH : n;
    if (!m_act) begin
      if (p) begin
        if (n == 0) m_done = 1;
        else begin m_act = 1; m_idx = 0; m_ph = 0; end
      end
    end else if (s) begin
      m_act = 0; m_note = 0;
    end else if (m_ph == BEAT + 1) begin
      if (m_idx + 1 < lim) begin m_idx++; m_ph = 0; end
      else if (lp) begin m_idx = 0; m_ph = 0; end
      else begin m_act = 0; m_note = 0; m_done = 1; end
    end else begin
      if (m_ph == 1) m_note = ram[m_idx];
      m_ph++;
    end
  endtask

  task automatic check_all();
    chk("playing", playing, m_act);
    chk("done", done, m_done);
    chk("note_out", note_out, m_note);
    chk("pos_play", pos_play, m_idx);
    chk("rd_addr", rd_addr, m_idx);
    chk("spk", spk, m_spk());
  endtask

  task automatic cyc(input bit p, input bit s);
    play = p; stop = s;
    @(posedge clk);
    m_step(p, s, loop_en, i_note);
    #1;
    play = 1'b0; stop = 1'b0;
    @(negedge clk);
    if (done) dn_cnt++;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic run_until(input int idx, input int ph, input int budget);
    int n;
    n = 0;
    while (!(m_act && m_idx == idx && m_ph == ph) && n < budget) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("wait_reach", (m_act && m_idx == idx && m_ph == ph) ? 1 : 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 6'($urandom_range(0, 63));
    m_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // empty buffer
    i_note = 6'd0; dn_cnt = 0;
    cyc(1'b1, 1'b0);
    run(3);
    chk("empty_done_cnt", dn_cnt, 1);

    // basic playback with a rest
    ram[0] = 6'd5; ram[1] = 6'd7; ram[2] = 6'd0; ram[3] = 6'd9;
    i_note = 6'd4; dn_cnt = 0;
    cyc(1'b1, 1'b0);
    run(44);
    chk("basic_done_cnt", dn_cnt, 1);

    // loop, then release loop_en inside beat 4
    ram[0] = 6'd10; ram[1] = 6'd20;
    i_note = 6'd2; loop_en = 1'b1; dn_cnt = 0;
    cyc(1'b1, 1'b0);
    run(34);
    loop_en = 1'b0;
    run(30);
    chk("loop_done_cnt", dn_cnt, 1);

    // play ignored mid-SOUND; stop wins over the GAP exit
    i_note = 6'd4; dn_cnt = 0;
    cyc(1'b1, 1'b0);
    run_until(1, 4, 40);
    cyc(1'b1, 1'b0);
    run_until(1, BEAT + 1, 20);
    cyc(1'b0, 1'b1);
    chk("stop_note", note_out, 0);
    run(5);
    chk("stop_done_cnt", dn_cnt, 0);

    // asynchronous reset in the middle of a gap, between clock edges
    cyc(1'b1, 1'b0);
    run_until(0, BEAT - GAP + 2, 30);
    #2 reset = 1'b0;
    m_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // live shrink of i_note while playing index 3 of 10
    for (int i = 0; i < 10; i++) ram[i] = 6'($urandom_range(0, 63));
    i_note = 6'd10; dn_cnt = 0;
    cyc(1'b1, 1'b0);
    run_until(3, 3, 60);
    i_note = 6'd2;
    run(15);
    chk("shrink_done_cnt", dn_cnt, 1);

    // randomized traffic
    i_note = 6'd6; loop_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 199) == 0) i_note = 6'($urandom_range(0, 45));
      if (!m_act && $urandom_range(0, 9) == 0)
        ram[$urandom_range(0, 39)] = 6'($urandom_range(0, 63));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Playback engine for the composition buffer: reads stored 6-bit note codes from the note RAM at indices 0..i_note-1 and holds each for one beat.
- Drives a square-wave speaker output, plus the current note code and index for the HEX/LED display.
- Sits beside the composer front end, as the read side of the same note RAM.
- Playback is started, stopped and looped by debounced single-cycle pulses from the board keys.

Parameters:
- DEPTH, 40, number of note RAM entries.
- NOTE_W, 6, note code width; code 0 is a rest.
- BEAT_CYCLES, 12_500_000, clocks each note is held, including the gap.
- GAP_CYCLES, 625_000, silent clocks at the end of each beat (articulation); must be less than BEAT_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- play  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- loop_en  in  1  level; when high, wrap to index 0 after the last note.
- i_note  in  6  number of valid notes (valid indices 0..i_note-1).
- rd_data  in  NOTE_W  RAM read data; synchronous, 1-cycle latency.
- rd_addr  out  6  RAM read address.
- note_out  out  NOTE_W  note code currently sounding (0 when silent).
- pos_play  out  6  index of the note currently sounding.
- playing  out  1  high from the first fetch until return to IDLE.
- done  out  1  single-cycle pulse on normal end of composition.
- spk  out  1  square-wave audio output.

Behaviour:
- Reset values: state IDLE; rd_addr 0; note_out 0; pos_play 0; playing 0; done 0; spk 0; beat counter 0; tone counter 0.
- States: IDLE, FETCH, WAIT_RD, SOUND, GAP.

IDLE:
- play with i_note==0: done pulses the next cycle; state stays IDLE.
- play with i_note>0: next state FETCH; rd_addr=0; pos_play=0; playing=1.

FETCH:
- Address is presented this cycle; go to WAIT_RD.

WAIT_RD:
- rd_data is valid this cycle.
- Latch note_out=rd_data; clear beat counter; go to SOUND.
- First note sounds 3 cycles after the play pulse.

SOUND:
- Count beat cycles.
- At beat count BEAT_CYCLES-GAP_CYCLES-1: go to GAP; force spk 0 (note_out keeps its code).

GAP:
- At beat count BEAT_CYCLES-1:
  - pos_play+1 < i_note: advance pos_play and rd_addr; go to FETCH.
  - Else, loop_en=1: pos_play=rd_addr=0; go to FETCH.
  - Else: done pulse; note_out=0; playing=0; go to IDLE.
- The fetch overhead of 2 cycles is added to each beat. Beat period is BEAT_CYCLES+2 clocks.

stop:
- In any non-IDLE state: go to IDLE next cycle; note_out=0; spk=0; playing=0; no done pulse.
- stop has priority over every other transition in the same cycle.

play while not IDLE:
- Ignored.

i_note changing mid-play:
- Sampled live at each GAP exit.
- If pos_play+1 >= the new i_note, playback ends (or wraps if loop_en=1).

Tone generation:
- note_out nonzero and state SOUND: spk toggles every half_period(note_out) clocks from the package LUT.
- Tone counter reloads on every note change, so each note starts with a fresh phase.
- Rest code 0, or any code >= NUM_NOTES: spk held 0 for the whole beat.

Widths:
- rd_addr and pos_play are 6-bit and never exceed DEPTH-1.
- Beat counter is $clog2(BEAT_CYCLES) bits.
- Tone counter is 17 bits.

Asynchronous reset mid-play:
- Outputs go immediately to their reset values.
- RAM contents are untouched.

Decomposition:
- Package music_pkg:
  - NOTE_W, DEPTH, NUM_NOTES.
  - The player state enum.
  - half_period(note) function / constant LUT for 50 MHz, e.g. code 1 = C4 = 95_556, code 10 = A4 = 56_818.
- Sub-module tone_gen (clk, reset, en, half_period, spk): free-running reloadable divider.
- note_player owns the FSM, beat counter and RAM addressing.

Test Plan:
- Override BEAT_CYCLES=8, GAP_CYCLES=2, LUT scaled to small half-periods, for all scenarios below.
- Basic playback: RAM={5,7,0,9}, i_note=4, play pulse.
  - note_out = 5, 7, 0, 9, each for 10 clocks.
  - pos_play = 0..3.
  - spk stays 0 during the rest and during each 2-clock gap.
  - Single done pulse after note 9's gap; playing falls the same cycle.
- Empty buffer: i_note=0, play pulse.
  - done pulses 1 cycle later.
  - playing never rises; rd_addr stays 0.
- Loop: i_note=2, loop_en=1.
  - pos_play sequence 0,1,0,1,0 across 5 beats with no done pulse.
  - Drop loop_en during beat 4: done after that beat.
- Stop/priority:
  - stop mid-SOUND of note 2 asserted together with the GAP exit: IDLE next cycle; note_out=0, spk=0, no done.
  - play asserted during SOUND has no effect.
- Async reset: assert reset low mid-GAP with no clock edge; all outputs are at reset values before the next edge.
- Live i_note shrink: playing index 3 of 10, set i_note=2; playback ends after the current beat with a done pulse.
